// File: rtl/imuldiv_div_frontend_pkg.sv
// Shared definitions for the divider front end: function codes, FSM states
// and small decode helpers.
package imuldiv_div_frontend_pkg;

    localparam logic [1:0] DIVFN_DIV  = 2'd0;
    localparam logic [1:0] DIVFN_DIVU = 2'd1;
    localparam logic [1:0] DIVFN_REM  = 2'd2;
    localparam logic [1:0] DIVFN_REMU = 2'd3;

    localparam logic [31:0] WORD_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] WORD_INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic fn_is_signed(input logic [1:0] fn);
        return (fn == DIVFN_DIV) || (fn == DIVFN_REM);
    endfunction

    function automatic logic fn_is_rem(input logic [1:0] fn);
        return (fn == DIVFN_REM) || (fn == DIVFN_REMU);
    endfunction

endpackage

// File: rtl/imuldiv_div_frontend_special.sv
// Resolves the cases the iterative divider must never see: divide-by-zero
// and signed overflow (INT_MIN / -1).
module imuldiv_div_frontend_special
    import imuldiv_div_frontend_pkg::*;
(
    input  logic [1:0]  fn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_special,
    output logic [31:0] special_result
);

    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        if (b == '0) begin
            is_special     = 1'b1;
            special_result = fn_is_rem(fn) ? a : WORD_ALL_ONES;
        end else if (fn_is_signed(fn) && (a == WORD_INT_MIN) && (b == WORD_ALL_ONES)) begin
            is_special     = 1'b1;
            special_result = fn_is_rem(fn) ? 32'h0 : WORD_INT_MIN;
        end
    end

endmodule

// File: rtl/imuldiv_div_frontend.sv
// Single-command request/response adapter in front of the iterative divider,
// with local fast path for special cases and a saturating latency counter.
module imuldiv_div_frontend #(
    parameter int TAG_W = 5,
    parameter int LAT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [1:0]       req_fn,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [31:0]      resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic [LAT_W-1:0] resp_lat
);
    import imuldiv_div_frontend_pkg::*;

    state_t             state;
    logic [1:0]         fn_reg;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [31:0]        result_reg;
    logic [LAT_W-1:0]   lat_reg;
    logic [LAT_W-1:0]   lat_next;
    logic               is_special;
    logic [31:0]        special_result;

    // Special-case detection looks at the incoming command so the fast-path
    // result is ready in the same cycle the command is accepted.
    imuldiv_div_frontend_special special_case (
        .fn             (req_fn),
        .a              (req_a),
        .b              (req_b),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign lat_next = (lat_reg == '1) ? lat_reg : lat_reg + LAT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fn_reg     <= DIVFN_DIV;
            a_reg      <= '0;
            b_reg      <= '0;
            tag_reg    <= '0;
            result_reg <= '0;
            lat_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        fn_reg  <= req_fn;
                        a_reg   <= req_a;
                        b_reg   <= req_b;
                        tag_reg <= req_tag;
                        lat_reg <= '0;
                        if (is_special) begin
                            result_reg <= special_result;
                            state      <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    lat_reg <= lat_next;
                    if (divreq_rdy) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    lat_reg <= lat_next;
                    if (divresp_val) begin
                        result_reg <= fn_is_rem(fn_reg) ? divresp_msg_result[63:32]
                                                        : divresp_msg_result[31:0];
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake signals depend on state only, never on the far side's val/rdy.
    assign req_rdy       = (state == IDLE);
    assign divreq_val    = (state == ISSUE);
    assign divresp_rdy   = (state == WAIT);
    assign resp_val      = (state == RESP);

    assign divreq_msg_fn = fn_is_signed(fn_reg);
    assign divreq_msg_a  = a_reg;
    assign divreq_msg_b  = b_reg;
    assign resp_result   = result_reg;
    assign resp_tag      = tag_reg;
    assign resp_lat      = lat_reg;

endmodule

// File: tb/tb_imuldiv_div_frontend.sv
// Directed-vector bench for imuldiv_div_frontend; the divider is played by
// hand-driven handshakes with known responses.
module tb_imuldiv_div_frontend;

    localparam int TAG_W = 5;
    localparam int LAT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_val = 1'b0;
    logic             req_rdy;
    logic [1:0]       req_fn = 2'd0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             divreq_msg_fn;
    logic [31:0]      divreq_msg_a;
    logic [31:0]      divreq_msg_b;
    logic             divreq_val;
    logic             divreq_rdy = 1'b0;
    logic [63:0]      divresp_msg_result = '0;
    logic             divresp_val = 1'b0;
    logic             divresp_rdy;
    logic             resp_val;
    logic             resp_rdy = 1'b0;
    logic [31:0]      resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic [LAT_W-1:0] resp_lat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imuldiv_div_frontend #(.TAG_W(TAG_W), .LAT_W(LAT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_val            (req_val),
        .req_rdy            (req_rdy),
        .req_fn             (req_fn),
        .req_a              (req_a),
        .req_b              (req_b),
        .req_tag            (req_tag),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .resp_val           (resp_val),
        .resp_rdy           (resp_rdy),
        .resp_result        (resp_result),
        .resp_tag           (resp_tag),
        .resp_lat           (resp_lat)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int n = 0;
        while (!req_rdy && n < 20) begin
            tick();
            n++;
        end
        check("req_rdy_before_send", 64'(req_rdy), 64'd1);
        req_val = 1'b1;
        req_fn  = fn;
        req_a   = a;
        req_b   = b;
        req_tag = tag;
        tick();
        req_val = 1'b0;
        req_a   = 32'hDEAD_BEEF;
        req_b   = 32'h1234_5678;
    endtask

    task automatic take_result(input logic [31:0] exp_result, input logic [TAG_W-1:0] exp_tag,
                               input logic [LAT_W-1:0] exp_lat);
        check("resp_val", 64'(resp_val), 64'd1);
        check("resp_result", 64'(resp_result), 64'(exp_result));
        check("resp_tag", 64'(resp_tag), 64'(exp_tag));
        check("resp_lat", 64'(resp_lat), 64'(exp_lat));
        check("req_rdy_in_resp", 64'(req_rdy), 64'd0);
        $display("txn tag=%0d result=%08h lat=%0d", resp_tag, resp_result, resp_lat);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        check("resp_val_after_accept", 64'(resp_val), 64'd0);
        check("req_rdy_after_accept", 64'(req_rdy), 64'd1);
    endtask

    // Command that must reach the divider; divider answers 'delay' cycles after taking the request.
    task automatic run_div(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input int delay, input logic [63:0] div_res,
                           input logic exp_sfn, input logic [31:0] exp_result,
                           input logic [LAT_W-1:0] exp_lat);
        int extra = 0;
        send(fn, a, b, tag);
        check("divreq_val", 64'(divreq_val), 64'd1);
        check("divreq_msg_fn", 64'(divreq_msg_fn), 64'(exp_sfn));
        check("divreq_msg_a", 64'(divreq_msg_a), 64'(a));
        check("divreq_msg_b", 64'(divreq_msg_b), 64'(b));
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        check("divresp_rdy_in_wait", 64'(divresp_rdy), 64'd1);
        for (int i = 0; i < delay - 1; i++) begin
            if (divreq_val) extra++;
            tick();
        end
        divresp_val        = 1'b1;
        divresp_msg_result = div_res;
        tick();
        divresp_val        = 1'b0;
        divresp_msg_result = 64'h0;
        check("no_second_divreq", 64'(extra), 64'd0);
        take_result(exp_result, tag, exp_lat);
    endtask

    task automatic run_fast(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag, input logic [31:0] exp_result);
        send(fn, a, b, tag);
        check("fast_no_divreq", 64'(divreq_val), 64'd0);
        take_result(exp_result, tag, '0);
    endtask

    initial begin : main
        logic [31:0] held_result;
        int          seen;

        repeat (3) tick();
        check("rst_req_rdy", 64'(req_rdy), 64'd1);
        check("rst_divreq_val", 64'(divreq_val), 64'd0);
        check("rst_divresp_rdy", 64'(divresp_rdy), 64'd0);
        check("rst_resp_val", 64'(resp_val), 64'd0);
        check("rst_resp_lat", 64'(resp_lat), 64'd0);
        check("rst_resp_result", 64'(resp_result), 64'd0);
        reset = 1'b0;
        tick();

        // DIVU 100/7 -> q=14, r=2; one ISSUE cycle plus 33 WAIT cycles.
        run_div(2'd1, 32'd100, 32'd7, 5'd9, 33, {32'd2, 32'd14}, 1'b0, 32'd14, 8'd34);
        // REM -7 % 2 -> -1.
        run_div(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd3, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                1'b1, 32'hFFFF_FFFF, 8'd6);

        // Fast paths.
        run_fast(2'd0, 32'd5, 32'd0, 5'd1, 32'hFFFF_FFFF);
        run_fast(2'd3, 32'd5, 32'd0, 5'd2, 32'd5);
        run_fast(2'd1, 32'd77, 32'd0, 5'd4, 32'hFFFF_FFFF);
        run_fast(2'd2, 32'hCAFE_0001, 32'd0, 5'd5, 32'hCAFE_0001);
        run_fast(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000);
        run_fast(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0);
        // Unsigned version of the overflow operands goes to the divider: q=0, r=0x80000000.
        run_div(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 3, {32'h8000_0000, 32'd0},
                1'b0, 32'd0, 8'd4);
        // REMU of the same operands selects the upper half.
        run_div(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 2, {32'h8000_0000, 32'd0},
                1'b0, 32'h8000_0000, 8'd3);

        // Latency counter saturates.
        run_div(2'd0, 32'd1000, 32'd10, 5'd11, 300, {32'd0, 32'd100}, 1'b1, 32'd100, 8'd255);

        // Stray divider response outside WAIT is ignored.
        divresp_val        = 1'b1;
        divresp_msg_result = 64'h1111_1111_2222_2222;
        check("stray_divresp_rdy", 64'(divresp_rdy), 64'd0);
        tick();
        divresp_val = 1'b0;
        check("stray_req_rdy", 64'(req_rdy), 64'd1);
        check("stray_resp_val", 64'(resp_val), 64'd0);

        // Backpressure on both sides: DIV 100/7 -> 14.
        send(2'd0, 32'd100, 32'd7, 5'd12);
        for (int i = 0; i < 4; i++) begin
            check("bp_divreq_val", 64'(divreq_val), 64'd1);
            check("bp_divreq_a", 64'(divreq_msg_a), 64'd100);
            check("bp_divreq_b", 64'(divreq_msg_b), 64'd7);
            check("bp_req_rdy", 64'(req_rdy), 64'd0);
            tick();
        end
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        tick();
        divresp_val        = 1'b1;
        divresp_msg_result = {32'd2, 32'd14};
        tick();
        divresp_val        = 1'b0;
        divresp_msg_result = 64'h0;
        held_result = 32'd14;
        for (int i = 0; i < 3; i++) begin
            check("bp_resp_val", 64'(resp_val), 64'd1);
            check("bp_resp_result", 64'(resp_result), 64'(held_result));
            check("bp_req_rdy_resp", 64'(req_rdy), 64'd0);
            tick();
        end
        // ISSUE 5 cycles + WAIT 2 cycles.
        take_result(32'd14, 5'd12, 8'd7);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_val) seen++;
            tick();
        end
        check("bp_single_result", 64'(seen), 64'd0);

        // Asynchronous reset while waiting on the divider.
        send(2'd1, 32'd50, 32'd3, 5'd13);
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        check("pre_rst_divresp_rdy", 64'(divresp_rdy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req_rdy", 64'(req_rdy), 64'd1);
        check("mid_rst_divreq_val", 64'(divreq_val), 64'd0);
        check("mid_rst_divresp_rdy", 64'(divresp_rdy), 64'd0);
        check("mid_rst_resp_val", 64'(resp_val), 64'd0);
        check("mid_rst_resp_lat", 64'(resp_lat), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        // DIVU 50/3 -> q=16, r=2.
        run_div(2'd1, 32'd50, 32'd3, 5'd14, 4, {32'd2, 32'd16}, 1'b0, 32'd16, 8'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
